// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: port 1 writes, port 2 reads.
// A prefetch path feeds a 2-entry output buffer to hide the RAM read latency.
module dp_ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              ram_we1,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [DATA_W-1:0] ram_din1,
  output logic              ram_we2,
  output logic [ADDR_W-1:0] ram_addr2,
  output logic [DATA_W-1:0] ram_din2,
  input  logic [DATA_W-1:0] ram_dout2
);

  localparam logic [ADDR_W:0] RAM_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   ram_cnt_reg, ram_cnt_next;
  logic              inflight_reg;
  logic [1:0]        out_cnt_reg, out_cnt_next;
  logic [DATA_W-1:0] buf0_reg, buf1_reg, buf0_next, buf1_next;

  logic       push, pop, issue;
  logic [2:0] occ;
  logic [1:0] base;

  assign s_ready = (ram_cnt_reg != RAM_FULL);
  assign m_valid = (out_cnt_reg != 2'd0);
  assign m_data  = buf0_reg;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Buffer occupancy once this cycle's capture and pop are accounted for
  assign occ   = {1'b0, out_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue = (ram_cnt_reg != '0) && (occ < 3'd2);
  assign base  = out_cnt_reg - {1'b0, pop};

  assign ram_we1   = push;
  assign ram_addr1 = wr_ptr_reg;
  assign ram_din1  = s_data;
  assign ram_we2   = 1'b0;
  assign ram_addr2 = rd_ptr_reg;
  assign ram_din2  = '0;

  assign count = (ADDR_W+2)'(ram_cnt_reg) + (ADDR_W+2)'(inflight_reg)
               + (ADDR_W+2)'(out_cnt_reg);

  always_comb begin
    buf0_next    = buf0_reg;
    buf1_next    = buf1_reg;
    ram_cnt_next = ram_cnt_reg + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
    out_cnt_next = out_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
    if (pop) buf0_next = buf1_reg;
    // Arriving word lands behind whatever survives this cycle's pop
    if (inflight_reg) begin
      if (base == 2'd0) buf0_next = ram_dout2;
      else              buf1_next = ram_dout2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      out_cnt_reg  <= '0;
      buf0_reg     <= '0;
      buf1_reg     <= '0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (issue) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      ram_cnt_reg  <= ram_cnt_next;
      inflight_reg <= issue;
      out_cnt_reg  <= out_cnt_next;
      buf0_reg     <= buf0_next;
      buf1_reg     <= buf1_next;
    end
  end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed bench for dp_ram_fifo_ctrl with a behavioural registered-read RAM
// and a queue scoreboard of accepted-but-not-yet-popped words.
module tb_dp_ram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0, s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid, m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W+1:0] count;
  logic              ram_we1, ram_we2;
  logic [ADDR_W-1:0] ram_addr1, ram_addr2;
  logic [DATA_W-1:0] ram_din1, ram_din2, ram_dout2;

  logic [DATA_W-1:0] mem [DEPTH];

  dp_ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_we1(ram_we1), .ram_addr1(ram_addr1), .ram_din1(ram_din1),
    .ram_we2(ram_we2), .ram_addr2(ram_addr2), .ram_din2(ram_din2),
    .ram_dout2(ram_dout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we1) mem[ram_addr1] <= ram_din1;
    ram_dout2 <= mem[ram_addr2];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] q[$];
  int   wptr_model = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  int   n_pop = 0, max_count = 0, cyc = 0, first_pop = -1, last_pop = -1;
  logic sm_valid, sr, last_push;
  logic [DATA_W-1:0] sm_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, model the coming edge
  task automatic do_cycle(input logic sv, input logic [DATA_W-1:0] sd, input logic mr);
    logic psh, pp;
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    sm_valid = m_valid; sm_data = m_data; sr = s_ready;
    check("count_vs_model", 32'(count), 32'(q.size()));
    check("ram_we2_zero", 32'(ram_we2), 32'd0);
    if (int'(count) > max_count) max_count = int'(count);
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", 32'(m_data), 32'(prev_data));
    end
    psh = s_valid & s_ready;
    pp  = m_valid & m_ready;
    if (psh) begin
      check("ram_we1", 32'(ram_we1), 32'd1);
      check("ram_addr1", 32'(ram_addr1), 32'(wptr_model % DEPTH));
      q.push_back(s_data);
      wptr_model++;
    end
    if (pp) begin
      check("pop_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        check("pop_data", 32'(m_data), 32'(q[0]));
        void'(q.pop_front());
      end
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    last_push  = psh;
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
    cyc++;
  endtask

  task automatic clr_stats();
    n_pop = 0; max_count = 0; cyc = 0; first_pop = -1; last_pop = -1;
  endtask

  initial begin
    int idx;
    // Reset state
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Test 1: two pushes, latency, then drain
    do_cycle(1, 8'd10, 0); check("t1_c0_valid", 32'(sm_valid), 32'd0);
    do_cycle(1, 8'd20, 0); check("t1_c1_valid", 32'(sm_valid), 32'd0);
    do_cycle(0, 8'd0, 0);  check("t1_c2_valid", 32'(sm_valid), 32'd0);
    do_cycle(0, 8'd0, 0);  check("t1_c3_valid", 32'(sm_valid), 32'd1);
    check("t1_c3_data", 32'(sm_data), 32'd10);
    check("t1_c3_count", 32'(count), 32'd2);
    do_cycle(0, 8'd0, 1);
    do_cycle(0, 8'd0, 1);  check("t1_c5_data", 32'(sm_data), 32'd20);
    do_cycle(0, 8'd0, 0);  check("t1_c6_valid", 32'(sm_valid), 32'd0);
    check("t1_c6_count", 32'(count), 32'd0);

    // Test 2: fill to full with consumer stalled
    for (int i = 0; i < 20; i++) do_cycle(1, 8'(i), 0);
    do_cycle(1, 8'd20, 0);
    check("t2_full_s_ready", 32'(sr), 32'd0);
    check("t2_full_count", 32'(count), 32'd18);
    check("t2_head", 32'(sm_data), 32'd0);
    check("t2_last_in", 32'(q[q.size()-1]), 32'd17);
    clr_stats();
    for (int i = 0; i < 40 && q.size() > 0; i++) do_cycle(0, 8'd0, 1);
    check("t2_drain_done", 32'(q.size()), 32'd0);
    check("t2_drain_pops", 32'(n_pop), 32'd18);
    do_cycle(0, 8'd0, 0);

    // Test 3: streaming 40 words back to back
    clr_stats(); idx = 0;
    for (int i = 0; i < 44; i++) begin
      do_cycle(idx < 40, 8'(idx), 1);
      if (last_push) idx++;
    end
    check("t3_pushed", 32'(idx), 32'd40);
    check("t3_pops", 32'(n_pop), 32'd40);
    check("t3_first_pop", 32'(first_pop), 32'd3);
    check("t3_no_gaps", 32'(last_pop - first_pop), 32'd39);
    check("t3_max_count_le3", 32'(max_count <= 3), 32'd1);

    // Test 4: random back-pressure, 100 words
    clr_stats(); idx = 0;
    for (int i = 0; i < 600 && n_pop < 100; i++) begin
      do_cycle(idx < 100, 8'(idx), 1'($urandom_range(0, 1)));
      if (last_push) idx++;
    end
    check("t4_pops", 32'(n_pop), 32'd100);
    check("t4_max_count_le18", 32'(max_count <= 18), 32'd1);

    // Test 5: reset mid-operation
    for (int i = 0; i < 5; i++) do_cycle(1, 8'(8'h30 + i), 0);
    do_cycle(0, 8'd0, 1);
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_valid", 32'(m_valid), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_s_ready", 32'(s_ready), 32'd1);
    q.delete(); wptr_model = 0; prev_stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    clr_stats();
    do_cycle(1, 8'hA5, 1);
    for (int i = 0; i < 10; i++) do_cycle(0, 8'd0, 1);
    check("t5_single_pop", 32'(n_pop), 32'd1);
    check("t5_empty_after", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
